// File: rtl/ext_pkg.sv
// Shared types and default widths for the immediate-extension pipeline.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BOFF  = 2'b11
  } ext_mode_t;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

endpackage

// File: rtl/ext_unit_pipe_if.sv
// Decode-side and ALU-side handshake bundle of the extension pipeline.
interface ext_unit_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );

endinterface

// File: rtl/ext_core.sv
// Combinational widening of an IN_W-bit immediate to OUT_W bits by mode.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] zext_s;
  logic [OUT_W-1:0] sext_s;
  logic [OUT_W-1:0] upper_s;
  logic [OUT_W-1:0] boff_s;

  assign zext_s  = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext_s  = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign upper_s = {imm, {(OUT_W-IN_W){1'b0}}};
  // Branch offsets are word-scaled; the two bits shifted out are sign copies.
  assign boff_s  = sext_s << 2;

  // Mode select of the extended value.
  always_comb begin
    ext = zext_s;
    case (mode)
      EXT_ZERO:  ext = zext_s;
      EXT_SIGN:  ext = sext_s;
      EXT_UPPER: ext = upper_s;
      EXT_BOFF:  ext = boff_s;
      default:   ext = zext_s;
    endcase
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered immediate-extension stage with a one-entry skid buffer so the
// decode side sees a ready that never depends combinationally on out_ready.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  ext_unit_pipe_if.slave  bus
);

  logic [OUT_W-1:0] new_data_s;
  logic             accept_s;
  logic             advance_s;

  logic             out_valid_r, out_valid_s;
  logic [OUT_W-1:0] out_data_r,  out_data_s;
  logic [1:0]       out_mode_r,  out_mode_s;
  logic             skid_valid_r, skid_valid_s;
  logic [OUT_W-1:0] skid_data_r,  skid_data_s;
  logic [1:0]       skid_mode_r,  skid_mode_s;
  logic             in_ready_r;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (bus.in_imm),
    .mode (ext_mode_t'(bus.in_mode)),
    .ext  (new_data_s)
  );

  assign accept_s  = bus.in_valid & in_ready_r;
  assign advance_s = ~out_valid_r | bus.out_ready;

  // Next-state of output and skid stages; skid always drains before new accepts.
  always_comb begin
    out_valid_s  = out_valid_r;
    out_data_s   = out_data_r;
    out_mode_s   = out_mode_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_mode_s  = skid_mode_r;
    if (advance_s) begin
      if (skid_valid_r) begin
        out_valid_s  = 1'b1;
        out_data_s   = skid_data_r;
        out_mode_s   = skid_mode_r;
        skid_valid_s = 1'b0;
      end else if (accept_s) begin
        out_valid_s = 1'b1;
        out_data_s  = new_data_s;
        out_mode_s  = bus.in_mode;
      end else begin
        out_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = new_data_s;
      skid_mode_s  = bus.in_mode;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Pipeline registers; in_ready is registered as the inverse of next skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {OUT_W{1'b0}};
      out_mode_r   <= 2'b00;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {OUT_W{1'b0}};
      skid_mode_r  <= 2'b00;
      in_ready_r   <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      out_mode_r   <= out_mode_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_mode_r  <= skid_mode_s;
      in_ready_r   <= ~skid_valid_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_mode  = out_mode_r;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe at 16->32 and 12->24 widths.
module tb_ext_unit_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ext_unit_pipe_if #(.IN_W(16), .OUT_W(32)) b16 ();
  ext_unit_pipe_if #(.IN_W(12), .OUT_W(24)) b12 ();

  ext_unit_pipe #(.IN_W(16), .OUT_W(32)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  ext_unit_pipe #(.IN_W(12), .OUT_W(24)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));

  int vectors = 0;
  int miscompares = 0;

  // Reference extension from arithmetic on the numeric value of the immediate.
  function automatic logic [63:0] ref_ext(int inw, int outw, logic [63:0] imm, int mode);
    longint mask, sv;
    mask = (longint'(1) << outw) - 1;
    sv   = longint'(imm);
    if (imm[inw-1]) sv = sv - (longint'(1) << inw);
    case (mode)
      0:       return imm;
      1:       return sv & mask;
      2:       return (imm << (outw - inw)) & mask;
      default: return (sv * 4) & mask;
    endcase
  endfunction

  task automatic drive16(input logic v, input logic [15:0] imm, input logic [1:0] m, input logic rdy);
    b16.in_valid = v; b16.in_imm = imm; b16.in_mode = m; b16.out_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive16(1'b0, 16'h0000, 2'b00, 1'b1);
    b12.in_valid = 1'b0; b12.in_imm = 12'h000; b12.in_mode = 2'b00; b12.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (b16.out_valid !== 1'b0 || b16.out_data !== 32'h0 || b16.out_mode !== 2'b00 || b16.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset16: valid=%b data=%h mode=%b rdy=%b, required 0/0/0/0",
               b16.out_valid, b16.out_data, b16.out_mode, b16.in_ready);
    end
    vectors++;
    if (b12.out_valid !== 1'b0 || b12.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset12: valid=%b rdy=%b, required 0/0", b12.out_valid, b12.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b valid=%b, required 1/0", b16.in_ready, b16.out_valid);
    end
  endtask

  task automatic test_zero();
    drive16(1'b1, 16'h8001, 2'b00, 1'b1);
    @(negedge clk);
    drive16(1'b0, 16'h0000, 2'b00, 1'b1);
    vectors++;
    if (b16.out_valid !== 1'b1 || b16.out_data !== 32'h0000_8001 || b16.out_mode !== 2'b00) begin
      miscompares++;
      $display("FAIL zero: valid=%b data=%h mode=%b, required 1/00008001/00",
               b16.out_valid, b16.out_data, b16.out_mode);
    end
    @(negedge clk);
    vectors++;
    if (b16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_drain: valid=%b, required 0", b16.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive16(1'b1, 16'h8001, 2'b01, 1'b1);
    @(negedge clk);
    vectors++;
    if (b16.out_data !== 32'hFFFF_8001 || b16.out_mode !== 2'b01 || b16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_sign: data=%h mode=%b rdy=%b, required ffff8001/01/1",
               b16.out_data, b16.out_mode, b16.in_ready);
    end
    drive16(1'b1, 16'h1234, 2'b10, 1'b1);
    @(negedge clk);
    drive16(1'b0, 16'h0000, 2'b00, 1'b1);
    vectors++;
    if (b16.out_valid !== 1'b1 || b16.out_data !== 32'h1234_0000 || b16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_upper: valid=%b data=%h rdy=%b, required 1/12340000/1",
               b16.out_valid, b16.out_data, b16.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_boff();
    drive16(1'b1, 16'hFFFF, 2'b11, 1'b1);
    @(negedge clk);
    vectors++;
    if (b16.out_data !== 32'hFFFF_FFFC || b16.out_mode !== 2'b11) begin
      miscompares++;
      $display("FAIL boff_neg: data=%h mode=%b, required fffffffc/11", b16.out_data, b16.out_mode);
    end
    drive16(1'b1, 16'h0004, 2'b11, 1'b1);
    @(negedge clk);
    drive16(1'b0, 16'h0000, 2'b00, 1'b1);
    vectors++;
    if (b16.out_data !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL boff_pos: data=%h, required 00000010", b16.out_data);
    end
    @(negedge clk);
  endtask

  // Leaves A on the output and B in the skid with out_ready low.
  task automatic stall_two();
    drive16(1'b1, 16'h0001, 2'b01, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'h0002, 2'b01, 1'b0);
    @(negedge clk);
    drive16(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic test_backpressure();
    stall_two();
    @(negedge clk);
    vectors++;
    if (b16.out_valid !== 1'b1 || b16.out_data !== 32'h0000_0001 || b16.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: valid=%b data=%h rdy=%b, required 1/00000001/0",
               b16.out_valid, b16.out_data, b16.in_ready);
    end
    b16.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b16.out_valid !== 1'b1 || b16.out_data !== 32'h0000_0002 || b16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b data=%h rdy=%b, required 1/00000002/1",
               b16.out_valid, b16.out_data, b16.in_ready);
    end
    @(negedge clk);
    vectors++;
    if (b16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: valid=%b, required 0", b16.out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    int seen;
    stall_two();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b16.out_ready = 1'b1;
    vectors++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall: valid=%b rdy=%b, required 0/0", b16.out_valid, b16.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b16.out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0 || b16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_flush: presented=%0d rdy=%b, required 0/1", seen, b16.in_ready);
    end
  endtask

  task automatic test_param12();
    b12.in_valid = 1'b1; b12.in_imm = 12'h800; b12.in_mode = 2'b01; b12.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b12.out_data !== 24'hFFF800) begin
      miscompares++;
      $display("FAIL p12_sign: data=%h, required fff800", b12.out_data);
    end
    b12.in_mode = 2'b10;
    @(negedge clk);
    b12.in_valid = 1'b0;
    vectors++;
    if (b12.out_data !== 24'h800000) begin
      miscompares++;
      $display("FAIL p12_upper: data=%h, required 800000", b12.out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_random16();
    logic [63:0] q[$];
    logic [1:0]  qm[$];
    logic [31:0] hold_d;
    logic        stalled;
    logic        drain;
    logic [63:0] exp_d;
    stalled = 1'b0;
    hold_d  = 32'h0;
    for (int i = 0; i < 400; i++) begin
      drain = (i >= 390);
      if (stalled) begin
        vectors++;
        if (b16.out_data !== hold_d) begin
          miscompares++;
          $display("FAIL r16_hold: data=%h, required %h", b16.out_data, hold_d);
        end
      end
      drive16(drain ? 1'b0 : 1'($urandom_range(1)), 16'($urandom), 2'($urandom_range(3)),
              drain ? 1'b1 : ($urandom_range(9) < 6));
      if (b16.in_valid && b16.in_ready) begin
        q.push_back(ref_ext(16, 32, 64'(b16.in_imm), int'(b16.in_mode)));
        qm.push_back(b16.in_mode);
      end
      if (b16.out_valid && b16.out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL r16_extra: data=%h, required no item", b16.out_data);
        end else begin
          exp_d = q.pop_front();
          if (b16.out_data !== exp_d[31:0] || b16.out_mode !== qm.pop_front()) begin
            miscompares++;
            $display("FAIL r16_data: data=%h, required %h", b16.out_data, exp_d[31:0]);
          end
        end
      end
      stalled = b16.out_valid && !b16.out_ready;
      hold_d  = b16.out_data;
      @(negedge clk);
    end
    vectors++;
    if (q.size() != 0 || b16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL r16_loss: pending=%0d valid=%b, required 0/0", q.size(), b16.out_valid);
    end
  endtask

  task automatic test_random12();
    logic [63:0] q[$];
    logic        drain;
    logic [63:0] exp_d;
    for (int i = 0; i < 300; i++) begin
      drain = (i >= 290);
      b12.in_valid  = drain ? 1'b0 : 1'($urandom_range(1));
      b12.in_imm    = 12'($urandom);
      b12.in_mode   = 2'($urandom_range(3));
      b12.out_ready = drain ? 1'b1 : 1'($urandom_range(1));
      if (b12.in_valid && b12.in_ready)
        q.push_back(ref_ext(12, 24, 64'(b12.in_imm), int'(b12.in_mode)));
      if (b12.out_valid && b12.out_ready) begin
        vectors++;
        exp_d = (q.size() != 0) ? q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        if (64'(b12.out_data) !== exp_d) begin
          miscompares++;
          $display("FAIL r12_data: data=%h, required %h", b12.out_data, exp_d);
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (q.size() != 0 || b12.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL r12_loss: pending=%0d valid=%b, required 0/0", q.size(), b12.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_boff();
    test_backpressure();
    test_reset_mid_stall();
    test_param12();
    test_random16();
    test_random12();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
